// File: rtl/riscv_pkg.sv
// Load/store unit types: FSM states, load funct3 encodings and access-size helpers.
// Latency: none, declarations only; backpressure: not applicable.
package riscv_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT_R,
      LSU_DONE
   } lsu_state_e;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      return ((size == SIZE_HALF) && offset[0]) ||
             ((size == SIZE_WORD) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Latency: combinational; backpressure: none.
module load_extender
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
      half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         FUNCT3_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
         FUNCT3_LH:  result_o = {{16{half_sel[15]}}, half_sel};
         FUNCT3_LBU: result_o = {24'h0, byte_sel};
         FUNCT3_LHU: result_o = {16'h0, half_sel};
         default:    result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store responder: aligns stores, runs req/gnt/rvalid to the data bus, extends loads.
// Latency: store 1+grant wait+1, load adds rvalid wait; stalls the pipeline until done, aborts on timeout.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [3:0]  mem_write_mask_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic        stall_o,
   output logic        load_valid_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o,
   output logic        timeout_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_e       state_q, state_d;
   logic [31:0]      addr_q, wdata_q, load_data_q, ext_data;
   logic [3:0]       be_q, be_d;
   logic [2:0]       funct3_q;
   logic             we_q, to_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       size;
   logic [31:0]      wdata_d;
   logic             req_any, misaligned, expired;

   load_extender u_load_extender (
      .rdata_i  (bus_rdata_i),
      .offset_i (addr_q[1:0]),
      .funct3_i (funct3_q),
      .result_o (ext_data)
   );

   // A store wins when both controls are raised; size comes from the mask for stores.
   always_comb begin
      req_any = mem_read_i | mem_write_i;
      if (mem_write_i) begin
         size = mem_write_mask_i[3] ? SIZE_WORD : (mem_write_mask_i[1] ? SIZE_HALF : SIZE_BYTE);
      end else begin
         case (funct3_i[1:0])
            2'b00:   size = SIZE_BYTE;
            2'b01:   size = SIZE_HALF;
            default: size = SIZE_WORD;
         endcase
      end
      misaligned = is_misaligned(size, addr_i[1:0]);
      be_d       = mem_write_i ? (mem_write_mask_i << addr_i[1:0]) : 4'hF;
      case (size)
         SIZE_BYTE: wdata_d = {4{store_data_i[7:0]}};
         SIZE_HALF: wdata_d = {2{store_data_i[15:0]}};
         default:   wdata_d = store_data_i;
      endcase
      expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
   end

   always_comb begin
      state_d      = state_q;
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      timeout_o    = 1'b0;
      load_valid_o = 1'b0;
      bus_req_o    = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (req_any) begin
               if (misaligned) begin
                  misaligned_o = 1'b1;
               end else begin
                  stall_o = 1'b1;
                  state_d = LSU_REQ;
               end
            end
         end
         LSU_REQ: begin
            stall_o = 1'b1;
            if (expired) begin
               timeout_o = 1'b1;
               state_d   = LSU_DONE;
            end else begin
               bus_req_o = 1'b1;
               if (bus_gnt_i) state_d = we_q ? LSU_DONE : LSU_WAIT_R;
            end
         end
         LSU_WAIT_R: begin
            stall_o = 1'b1;
            if (expired) begin
               timeout_o = 1'b1;
               state_d   = LSU_DONE;
            end else if (bus_rvalid_i) begin
               state_d = LSU_DONE;
            end
         end
         LSU_DONE: begin
            load_valid_o = ~we_q & ~to_q;
            state_d      = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= LSU_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         funct3_q    <= '0;
         we_q        <= 1'b0;
         to_q        <= 1'b0;
         cnt_q       <= '0;
         load_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == LSU_IDLE && state_d == LSU_REQ) begin
            addr_q   <= addr_i;
            wdata_q  <= mem_write_i ? wdata_d : '0;
            be_q     <= be_d;
            funct3_q <= funct3_i;
            we_q     <= mem_write_i;
            to_q     <= 1'b0;
            cnt_q    <= '0;
         end else if (state_q == LSU_REQ && state_d == LSU_WAIT_R) begin
            cnt_q <= '0;
         end else if (state_q == LSU_REQ || state_q == LSU_WAIT_R) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (timeout_o) to_q <= 1'b1;
         if (state_q == LSU_WAIT_R && bus_rvalid_i && !expired) load_data_q <= ext_data;
      end
   end

   assign load_data_o = load_data_q;
   assign bus_we_o    = we_q;
   assign bus_addr_o  = {addr_q[31:2], 2'b00};
   assign bus_be_o    = be_q;
   assign bus_wdata_o = wdata_q;

   assert property (@(posedge clk_i) disable iff (!rst_ni)
                    !(state_q == LSU_IDLE && mem_read_i && mem_write_i));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small responding bus model.
// Latency: n/a; backpressure: grant and rvalid delays are set per access.
module tb_load_store_unit;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        mem_read_i, mem_write_i;
   logic [3:0]  mem_write_mask_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, store_data_i;
   logic        stall_o, load_valid_o, misaligned_o, timeout_o;
   logic [31:0] load_data_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_gnt_i, bus_rvalid_i;
   logic [31:0] bus_rdata_i;

   int n_checks = 0;
   int n_fail   = 0;

   int          stalls;
   bit          got_valid, got_to;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_be;
   logic        r_we;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .mem_read_i       (mem_read_i),
      .mem_write_i      (mem_write_i),
      .mem_write_mask_i (mem_write_mask_i),
      .funct3_i         (funct3_i),
      .addr_i           (addr_i),
      .store_data_i     (store_data_i),
      .stall_o          (stall_o),
      .load_valid_o     (load_valid_o),
      .load_data_o      (load_data_o),
      .misaligned_o     (misaligned_o),
      .timeout_o        (timeout_o),
      .bus_req_o        (bus_req_o),
      .bus_we_o         (bus_we_o),
      .bus_addr_o       (bus_addr_o),
      .bus_be_o         (bus_be_o),
      .bus_wdata_o      (bus_wdata_o),
      .bus_gnt_i        (bus_gnt_i),
      .bus_rvalid_i     (bus_rvalid_i),
      .bus_rdata_i      (bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic start(input logic rd, input logic wr, input logic [3:0] mask,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
      mem_read_i       = rd;
      mem_write_i      = wr;
      mem_write_mask_i = mask;
      funct3_i         = f3;
      addr_i           = addr;
      store_data_i     = data;
   endtask

   // Called at a negedge with the request already driven; returns at the negedge after DONE.
   task automatic run_access(input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
      int reqc, waitc;
      bit granted, done, seen_req;
      stalls = 0; got_valid = 0; got_to = 0;
      reqc = 0; waitc = 0; granted = 0; done = 0; seen_req = 0;
      r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         bus_gnt_i    = 1'b0;
         bus_rvalid_i = 1'b0;
         if (bus_req_o) begin
            if (!seen_req) begin
               r_addr = bus_addr_o; r_wdata = bus_wdata_o; r_be = bus_be_o; r_we = bus_we_o;
               seen_req = 1;
            end
            if (reqc == gnt_wait) begin
               bus_gnt_i = 1'b1;
               granted   = 1;
            end
            reqc++;
         end else if (granted) begin
            if (waitc == rv_wait) begin
               bus_rvalid_i = 1'b1;
               bus_rdata_i  = rdata;
            end
            waitc++;
         end
         #1;
         got_valid |= load_valid_o;
         got_to    |= timeout_o;
         if (stall_o) stalls++;
         else if (i > 0) done = 1;
         @(negedge clk_i);
         mem_read_i  = 1'b0;
         mem_write_i = 1'b0;
      end
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      chk("access_completes", 32'(done), 32'd1);
   endtask

   task automatic misaligned_case(input string tag, input logic rd, input logic wr,
                                  input logic [3:0] mask, input logic [2:0] f3, input logic [31:0] addr);
      start(rd, wr, mask, f3, addr, 32'h1234_5678);
      #1;
      chk({tag, "_pulse"}, 32'(misaligned_o), 32'd1);
      chk({tag, "_nostall"}, 32'(stall_o), 32'd0);
      chk({tag, "_noreq"}, 32'(bus_req_o), 32'd0);
      @(negedge clk_i);
      start(0, 0, 4'h0, 3'b000, 32'h0, 32'h0);
      #1;
      chk({tag, "_pulse_end"}, 32'(misaligned_o), 32'd0);
      chk({tag, "_noreq_after"}, 32'(bus_req_o), 32'd0);
      @(negedge clk_i);
   endtask

   initial begin
      rst_ni       = 1'b0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      start(0, 0, 4'h0, 3'b000, 32'h0, 32'h0);
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_load_valid", 32'(load_valid_o), 32'd0);
      chk("rst_load_data", load_data_o, 32'h0);
      chk("rst_bus_req", 32'(bus_req_o), 32'd0);
      chk("rst_bus_addr", bus_addr_o, 32'h0);
      chk("rst_bus_be", 32'(bus_be_o), 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // SW with two grant-wait cycles
      start(0, 1, 4'b1111, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
      run_access(2, 99, 32'h0);
      chk("sw_stalls", 32'(stalls), 32'd4);
      chk("sw_no_valid", 32'(got_valid), 32'd0);
      chk("sw_addr", r_addr, 32'h0000_0100);
      chk("sw_be", 32'(r_be), 32'hF);
      chk("sw_wdata", r_wdata, 32'hDEAD_BEEF);
      chk("sw_we", 32'(r_we), 32'd1);
      chk("sw_load_data_kept", load_data_o, 32'h0);

      start(0, 1, 4'b0001, 3'b000, 32'h0000_0103, 32'h0000_00A5);
      run_access(0, 99, 32'h0);
      chk("sb_stalls", 32'(stalls), 32'd2);
      chk("sb_addr", r_addr, 32'h0000_0100);
      chk("sb_be", 32'(r_be), 32'h8);
      chk("sb_wdata", r_wdata, 32'hA5A5_A5A5);

      start(0, 1, 4'b0011, 3'b001, 32'h0000_0102, 32'h0000_BEEF);
      run_access(0, 99, 32'h0);
      chk("sh_be", 32'(r_be), 32'hC);
      chk("sh_wdata", r_wdata, 32'hBEEF_BEEF);

      start(1, 0, 4'b0000, 3'b000, 32'h0000_0102, 32'h0);
      run_access(0, 0, 32'h0080_FF00);
      chk("lb_stalls", 32'(stalls), 32'd3);
      chk("lb_valid", 32'(got_valid), 32'd1);
      chk("lb_be", 32'(r_be), 32'hF);
      chk("lb_we", 32'(r_we), 32'd0);
      chk("lb_data", load_data_o, 32'hFFFF_FF80);

      start(1, 0, 4'b0000, 3'b100, 32'h0000_0102, 32'h0);
      run_access(0, 0, 32'h0080_FF00);
      chk("lbu_data", load_data_o, 32'h0000_0080);

      start(1, 0, 4'b0000, 3'b101, 32'h0000_0102, 32'h0);
      run_access(0, 0, 32'h0080_FF00);
      chk("lhu_data", load_data_o, 32'h0000_0080);

      start(1, 0, 4'b0000, 3'b001, 32'h0000_0100, 32'h0);
      run_access(1, 2, 32'h0080_FF00);
      chk("lh_stalls", 32'(stalls), 32'd6);
      chk("lh_data", load_data_o, 32'hFFFF_FF00);

      start(1, 0, 4'b0000, 3'b010, 32'h0000_0100, 32'h0);
      run_access(0, 0, 32'h0080_FF00);
      chk("lw_data", load_data_o, 32'h0080_FF00);

      misaligned_case("mis_lw", 1, 0, 4'b0000, 3'b010, 32'h0000_0101);
      misaligned_case("mis_sh", 0, 1, 4'b0011, 3'b001, 32'h0000_0101);
      chk("mis_load_data_kept", load_data_o, 32'h0080_FF00);

      // No rvalid: abort after the counter reaches 4 in WAIT_R
      start(1, 0, 4'b0000, 3'b010, 32'h0000_0108, 32'h0);
      run_access(0, 999, 32'h0);
      chk("to_pulse", 32'(got_to), 32'd1);
      chk("to_stalls", 32'(stalls), 32'd7);
      chk("to_no_valid", 32'(got_valid), 32'd0);
      chk("to_load_data_kept", load_data_o, 32'h0080_FF00);

      // Reset asserted while waiting for read data
      start(1, 0, 4'b0000, 3'b010, 32'h0000_0100, 32'h0);
      @(negedge clk_i);
      start(0, 0, 4'h0, 3'b000, 32'h0, 32'h0);
      bus_gnt_i = 1'b1;
      @(negedge clk_i);
      bus_gnt_i = 1'b0;
      #1;
      chk("wr_stall_before_rst", 32'(stalls >= 0 && stall_o), 32'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("arst_stall", 32'(stall_o), 32'd0);
      chk("arst_bus_req", 32'(bus_req_o), 32'd0);
      chk("arst_load_data", load_data_o, 32'h0);
      chk("arst_bus_addr", bus_addr_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      start(1, 0, 4'b0000, 3'b010, 32'h0000_0104, 32'h0);
      run_access(0, 0, 32'h1234_5678);
      chk("post_rst_stalls", 32'(stalls), 32'd3);
      chk("post_rst_valid", 32'(got_valid), 32'd1);
      chk("post_rst_addr", r_addr, 32'h0000_0104);
      chk("post_rst_data", load_data_o, 32'h1234_5678);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
